// File: rtl/vector_mem_responder_if.sv
// Bus bundle between the vector load/store unit (plus host dump port) and the
// memory-side responder.
interface vector_mem_responder_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0]   address_RAM;
    logic [DATA_W/8-1:0] byteena_RAM;
    logic [DATA_W-1:0]   writeData_RAM;
    logic                rden_RAM;
    logic                wren_RAM;
    logic [DATA_W-1:0]   readData_RAM;
    logic                rvalid_RAM;
    logic                host_rd;
    logic [ADDR_W-1:0]   host_addr;
    logic                host_grant;
    logic [DATA_W-1:0]   host_rdata;
    logic                host_valid;
    logic                addr_err;

    modport master (
        output address_RAM, byteena_RAM, writeData_RAM, rden_RAM, wren_RAM,
        output host_rd, host_addr,
        input  readData_RAM, rvalid_RAM, host_grant, host_rdata, host_valid, addr_err
    );

    modport slave (
        input  address_RAM, byteena_RAM, writeData_RAM, rden_RAM, wren_RAM,
        input  host_rd, host_addr,
        output readData_RAM, rvalid_RAM, host_grant, host_rdata, host_valid, addr_err
    );
endinterface

// File: rtl/vector_mem_responder.sv
// Byte-enabled data memory with a fixed-latency read pipeline shared by the core
// port and a low-priority host dump port; each source has its own held output.
module vector_mem_responder #(
    parameter int DATA_W       = 256,
    parameter int ADDR_W       = 14,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    vector_mem_responder_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PS    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

    function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
        return (32'(a) >= DEPTH);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] st_data_q [PS];
    logic [PS-1:0]     pv_q, pv_d, ph_q, ph_d, po_q, po_d;

    logic [DATA_W-1:0] core_data_q, core_data_d, host_data_q, host_data_d;
    logic              core_valid_q, core_valid_d, host_valid_q, host_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              host_grant_s, iss_v_s, iss_host_s, iss_oor_s;
    logic [ADDR_W-1:0] iss_addr_s;
    logic [IDX_W-1:0]  iss_idx_s, wr_idx_s;
    logic              wr_en_s, core_oor_s, host_oor_s;
    logic              ret_v_s, ret_host_s, ret_oor_s;
    logic [DATA_W-1:0] ret_data_s, ret_word_s;

    // Request issue: core always wins the single array read port
    always_comb begin
        host_grant_s = bus.host_rd & ~bus.rden_RAM & ~bus.wren_RAM;
        iss_v_s      = bus.rden_RAM | host_grant_s;
        iss_host_s   = ~bus.rden_RAM & host_grant_s;
        if (bus.rden_RAM) begin
            iss_addr_s = bus.address_RAM;
        end else begin
            iss_addr_s = bus.host_addr;
        end
        iss_oor_s  = addr_oor(iss_addr_s);
        iss_idx_s  = iss_addr_s[IDX_W-1:0];
        wr_idx_s   = bus.address_RAM[IDX_W-1:0];
        wr_en_s    = bus.wren_RAM & ~addr_oor(bus.address_RAM);
        core_oor_s = (bus.rden_RAM | bus.wren_RAM) & addr_oor(bus.address_RAM);
        host_oor_s = host_grant_s & addr_oor(bus.host_addr);
    end

    // Array write port; no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.byteena_RAM[i]) begin
                    mem_q[wr_idx_s][8*i +: 8] <= bus.writeData_RAM[8*i +: 8];
                end
            end
        end
    end

    // Registered array read and data delay stages (old data on same-edge write)
    always_ff @(posedge clk) begin
        if (iss_v_s) begin
            st_data_q[0] <= mem_q[iss_idx_s];
        end
        for (int k = 1; k < PS; k++) begin
            st_data_q[k] <= st_data_q[k-1];
        end
    end

    // Tag pipeline: valid, source and out-of-range travel alongside the data
    always_comb begin
        pv_d    = pv_q;
        ph_d    = ph_q;
        po_d    = po_q;
        pv_d[0] = iss_v_s;
        ph_d[0] = iss_host_s;
        po_d[0] = iss_oor_s;
        for (int k = 1; k < PS; k++) begin
            pv_d[k] = pv_q[k-1];
            ph_d[k] = ph_q[k-1];
            po_d[k] = po_q[k-1];
        end
    end

    // Return point: with a latency of one the output registers sample the array directly
    always_comb begin
        if (READ_LATENCY == 1) begin
            ret_v_s    = iss_v_s;
            ret_host_s = iss_host_s;
            ret_oor_s  = iss_oor_s;
            ret_data_s = mem_q[iss_idx_s];
        end else begin
            ret_v_s    = pv_q[PS-1];
            ret_host_s = ph_q[PS-1];
            ret_oor_s  = po_q[PS-1];
            ret_data_s = st_data_q[PS-1];
        end
    end

    // Steer the returning word to its own source's output register
    always_comb begin
        core_data_d  = core_data_q;
        core_valid_d = 1'b0;
        host_data_d  = host_data_q;
        host_valid_d = 1'b0;
        if (ret_oor_s) begin
            ret_word_s = {DATA_W{1'b0}};
        end else begin
            ret_word_s = ret_data_s;
        end
        if (ret_v_s) begin
            if (ret_host_s) begin
                host_data_d  = ret_word_s;
                host_valid_d = 1'b1;
            end else begin
                core_data_d  = ret_word_s;
                core_valid_d = 1'b1;
            end
        end else begin
            core_valid_d = 1'b0;
            host_valid_d = 1'b0;
        end
        addr_err_d = addr_err_q | core_oor_s | host_oor_s;
    end

    // Control and output state; reset drops in-flight reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q         <= {PS{1'b0}};
            ph_q         <= {PS{1'b0}};
            po_q         <= {PS{1'b0}};
            core_data_q  <= {DATA_W{1'b0}};
            core_valid_q <= 1'b0;
            host_data_q  <= {DATA_W{1'b0}};
            host_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            pv_q         <= pv_d;
            ph_q         <= ph_d;
            po_q         <= po_d;
            core_data_q  <= core_data_d;
            core_valid_q <= core_valid_d;
            host_data_q  <= host_data_d;
            host_valid_q <= host_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign bus.host_grant   = host_grant_s;
    assign bus.readData_RAM = core_data_q;
    assign bus.rvalid_RAM   = core_valid_q;
    assign bus.host_rdata   = host_data_q;
    assign bus.host_valid   = host_valid_q;
    assign bus.addr_err     = addr_err_q;
endmodule
